// File: rtl/arf054b256e1r1w0cbbeheaa4acw_pkg.sv
// Shared types and sizes for the register-file write-port input stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package arf054b256e1r1w0cbbeheaa4acw_pkg;

    localparam int DWIDTH        = 54;
    localparam int AWIDTH        = 8;
    localparam int WR_FIFO_DEPTH = 2;
    // Cycles a popped write stays in the shadow register (array write latency).
    localparam int WR_LAT        = 1;

    typedef struct packed {
        logic [AWIDTH-1:0] addr;
        logic [DWIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_wr_byp_sel.sv
// Priority address match over three write candidates for read-bypass forwarding.
// Latency: purely combinational.
// Backpressure: none; c0 has highest priority, then c1, then c2.
module arf054b256e1r1w0cbbeheaa4acw_wr_byp_sel
    import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
(
    input  logic              c0_vld,
    input  wr_req_t           c0_req,
    input  logic              c1_vld,
    input  wr_req_t           c1_req,
    input  logic              c2_vld,
    input  wr_req_t           c2_req,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DWIDTH-1:0] rd_byp_data
);

    logic [2:0] match;

    // Match each candidate, then pick the youngest matching one; zero data on miss.
    always_comb begin
        match[0]    = c0_vld && (c0_req.addr == rd_addr);
        match[1]    = c1_vld && (c1_req.addr == rd_addr);
        match[2]    = c2_vld && (c2_req.addr == rd_addr);
        rd_hit      = |match;
        rd_byp_data = '0;
        if (match[0]) begin
            rd_byp_data = c0_req.data;
        end else if (match[1]) begin
            rd_byp_data = c1_req.data;
        end else if (match[2]) begin
            rd_byp_data = c2_req.data;
        end
    end

endmodule

// File: rtl/arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv
// Write-port input stage: 2-entry skid FIFO feeding the array write port, optional read bypass
// (ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN). Latency: accept at N, earliest wr_en at N+1.
// Backpressure: in_ready from registered count only; wr_stall holds the head entry in place.
module arf054b256e1r1w0cbbeheaa4acw_wr_stage
    import arf054b256e1r1w0cbbeheaa4acw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              wr_stall,
    output logic              wr_en,
    output logic [AWIDTH-1:0] wr_addr,
    output logic [DWIDTH-1:0] wr_data,
    input  logic [AWIDTH-1:0] rd_addr,
    output logic              rd_hit,
    output logic [DWIDTH-1:0] rd_byp_data,
    output logic [1:0]        occupancy
);

    wr_req_t    mem_q [WR_FIFO_DEPTH];
    wr_req_t    mem_d [WR_FIFO_DEPTH];
    logic [1:0] count_q, count_d;
    logic       head_q, head_d;
    logic       tail_q, tail_d;
    // Held low for the first cycle after reset so no request is taken while coming out of reset.
    logic       rdy_q, rdy_d;
    logic       live;
    logic       not_empty;
    logic       push;
    wr_req_t    head_req;

    assign live      = ~rst;
    assign not_empty = (count_q != 2'd0);
    assign head_req  = mem_q[head_q];

    // Handshake and write-port outputs; everything reads as zero while reset is asserted.
    always_comb begin
        in_ready  = live && rdy_q && (count_q != 2'(WR_FIFO_DEPTH));
        wr_en     = live && not_empty && !wr_stall;
        wr_addr   = (live && not_empty) ? head_req.addr : '0;
        wr_data   = (live && not_empty) ? head_req.data : '0;
        occupancy = live ? count_q : 2'd0;
        push      = in_valid && in_ready;
    end

    // FIFO next state: push writes the tail slot, pop advances the head.
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q + {1'b0, push} - {1'b0, wr_en};
        head_d  = head_q ^ wr_en;
        tail_d  = tail_q ^ push;
        rdy_d   = 1'b1;
        if (push) begin
            mem_d[tail_q] = wr_req_t'{addr: in_addr, data: in_data};
        end
    end

    // Control state; reset discards buffered requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            rdy_q   <= rdy_d;
        end
    end

    // Entry storage is never reset; validity comes from the count.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
    logic    shadow_vld_q, shadow_vld_d;
    wr_req_t shadow_q, shadow_d;

    // Shadow keeps the just-popped write visible until the array reflects it.
    always_comb begin
        shadow_vld_d = wr_en;
        shadow_d     = wr_en ? head_req : shadow_q;
    end

    // Shadow valid bit clears on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_vld_q <= 1'b0;
        end else begin
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Shadow payload carries no reset.
    always_ff @(posedge clk) begin
        shadow_q <= shadow_d;
    end

    // Tail (youngest) is the other slot and only valid when both are full.
    arf054b256e1r1w0cbbeheaa4acw_wr_byp_sel u_byp_sel (
        .c0_vld      (live && (count_q == 2'd2)),
        .c0_req      (mem_q[~head_q]),
        .c1_vld      (live && not_empty),
        .c1_req      (head_req),
        .c2_vld      (live && shadow_vld_q),
        .c2_req      (shadow_q),
        .rd_addr     (rd_addr),
        .rd_hit      (rd_hit),
        .rd_byp_data (rd_byp_data)
    );
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^rd_addr;
    assign rd_hit         = 1'b0;
    assign rd_byp_data    = '0;
`endif

endmodule

// File: tb/tb_arf054b256e1r1w0cbbeheaa4acw_wr_stage.sv
module tb_arf054b256e1r1w0cbbeheaa4acw_wr_stage;
    import arf054b256e1r1w0cbbeheaa4acw_pkg::*;

`ifdef ARF054B256E1R1W0CBBEHEAA4ACW_WR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk      = 1'b0;
    logic              rst      = 1'b1;
    logic              in_valid = 1'b0;
    logic              wr_stall = 1'b0;
    logic [AWIDTH-1:0] in_addr  = '0;
    logic [AWIDTH-1:0] rd_addr  = '0;
    logic [DWIDTH-1:0] in_data  = '0;
    logic              in_ready;
    logic              wr_en;
    logic [AWIDTH-1:0] wr_addr;
    logic [DWIDTH-1:0] wr_data;
    logic              rd_hit;
    logic [DWIDTH-1:0] rd_byp_data;
    logic [1:0]        occupancy;

    int checks   = 0;
    int failures = 0;

    // Reference model: in-order queue of accepted writes, last-popped write, ready flag.
    wr_req_t q[$];
    bit      m_rdy  = 1'b0;
    bit      sh_vld = 1'b0;
    wr_req_t sh;

    always #5 clk = ~clk;

    arf054b256e1r1w0cbbeheaa4acw_wr_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .wr_stall    (wr_stall),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr),
        .rd_hit      (rd_hit),
        .rd_byp_data (rd_byp_data),
        .occupancy   (occupancy)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One clock: check outputs at negedge against the model, advance the model at posedge.
    task automatic cycle();
        bit                act;
        int                cnt;
        bit                e_rdy;
        bit                e_wen;
        bit                e_hit;
        bit                found;
        logic [DWIDTH-1:0] e_byp;
        logic [AWIDTH-1:0] e_addr;
        logic [DWIDTH-1:0] e_data;
        bit                push;
        @(negedge clk);
        act    = !rst;
        cnt    = q.size();
        e_rdy  = act && m_rdy && (cnt < 2);
        e_wen  = act && (cnt > 0) && !wr_stall;
        e_addr = (act && cnt > 0) ? q[0].addr : '0;
        e_data = (act && cnt > 0) ? q[0].data : '0;
        e_hit  = 1'b0;
        e_byp  = '0;
        found  = 1'b0;
        if (BYP && act) begin
            for (int i = cnt - 1; i >= 0; i--) begin
                if (!found && q[i].addr == rd_addr) begin
                    found = 1'b1;
                    e_byp = q[i].data;
                end
            end
            if (!found && sh_vld && sh.addr == rd_addr) begin
                found = 1'b1;
                e_byp = sh.data;
            end
            e_hit = found;
        end
        check_eq("in_ready", 64'(in_ready), 64'(e_rdy));
        check_eq("wr_en", 64'(wr_en), 64'(e_wen));
        check_eq("wr_addr", 64'(wr_addr), 64'(e_addr));
        check_eq("wr_data", 64'(wr_data), 64'(e_data));
        check_eq("occupancy", 64'(occupancy), 64'(act ? cnt : 0));
        check_eq("rd_hit", 64'(rd_hit), 64'(e_hit));
        check_eq("rd_byp_data", 64'(rd_byp_data), 64'(e_byp));
        push = in_valid && e_rdy;
        @(posedge clk);
        if (rst) begin
            q.delete();
            sh_vld = 1'b0;
            m_rdy  = 1'b0;
        end else begin
            sh_vld = e_wen;
            if (e_wen) begin
                sh = q.pop_front();
            end
            if (push) begin
                q.push_back(wr_req_t'{addr: in_addr, data: in_data});
            end
            m_rdy = 1'b1;
        end
        #1;
    endtask

    task automatic drive(input bit vld, input logic [AWIDTH-1:0] a, input logic [DWIDTH-1:0] d);
        in_valid = vld;
        in_addr  = a;
        in_data  = d;
        cycle();
    endtask

    initial begin
        // Let the reset take effect before the first comparison.
        @(posedge clk);
        #1;
        repeat (3) cycle();
        rst = 1'b0;
        cycle();
        cycle();

        // Single write.
        drive(1'b1, 8'h12, 54'h2A_BCDE_F012_3456);
        drive(1'b0, '0, '0);
        cycle();

        // Stall and backpressure.
        wr_stall = 1'b1;
        drive(1'b1, 8'h01, 54'h111);
        drive(1'b1, 8'h02, 54'h222);
        drive(1'b0, '0, '0);
        cycle();
        wr_stall = 1'b0;
        repeat (3) cycle();

        // Streaming with simultaneous push and pop.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 8'(i), 54'({$urandom(), $urandom()}));
        end
        drive(1'b0, '0, '0);
        repeat (2) cycle();

        // Bypass priority on repeated address.
        rd_addr  = 8'h40;
        wr_stall = 1'b1;
        drive(1'b1, 8'h40, 54'h0AAAA);
        drive(1'b1, 8'h40, 54'h0BBBB);
        drive(1'b0, '0, '0);
        cycle();
        wr_stall = 1'b0;
        repeat (4) cycle();

        // Reset with two requests buffered.
        wr_stall = 1'b1;
        drive(1'b1, 8'h05, 54'h555);
        drive(1'b1, 8'h06, 54'h666);
        in_valid = 1'b0;
        rst      = 1'b1;
        cycle();
        cycle();
        rst      = 1'b0;
        wr_stall = 1'b0;
        repeat (4) cycle();

        // Randomized traffic on a small address range to exercise matches.
        for (int i = 0; i < 3000; i++) begin
            wr_stall = ($urandom_range(0, 9) < 3);
            rd_addr  = 8'($urandom_range(0, 7));
            rst      = ($urandom_range(0, 199) == 0);
            drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 54'({$urandom(), $urandom()}));
        end
        rst = 1'b0;
        drive(1'b0, '0, '0);
        wr_stall = 1'b0;
        repeat (3) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
